pwm_output_controller: RTL and testbench

Sequences the 16 output pins from the configuration registers held by the SPI register bank: per-pin output enable, per-pin PWM select, and one shared 8-bit duty cycle. Contains the prescaler and the 8-bit period counter that generate the shared PWM waveform. Double-buffers the duty cycle so that a mid-period SPI write never produces a glitched period. Sits between the SPI register bank outputs and the chip output pins.

---
 rtl/pwm_output_controller.sv | 89 ++++++++
 tb/tb_pwm_output_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_output_controller.sv
// Purpose: drives the 16 output pins from the SPI enable/select registers and a
//          shared, double-buffered 8-bit PWM duty cycle (prescaler + 8-bit period counter).
// Latency: out, pwm_level and period_start are registered, one cycle after cnt/duty_active/enables.
// Backpressure: none; free-running, inputs are level-sampled every clk.
//
// Ports:
//   clk, rst_n              system clock, synchronous active-low reset
//   en_reg_out_15_8/7_0     per-pin output enable
//   en_reg_pwm_15_8/7_0     per-pin PWM select (1 = follow PWM, 0 = static high)
//   pwm_duty_cycle          requested duty, captured only at period boundaries
//   out                     registered pin drive
//   pwm_level               registered shared PWM waveform
//   period_start            one-cycle pulse in the first cycle of each PWM period
module pwm_output_controller #(
  parameter int unsigned CLK_DIV = 3000,
  parameter int unsigned DIV_W   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        pwm_level,
  output logic        period_start
);

  // Terminal prescaler count; CLK_DIV must fit in DIV_W bits.
  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] presc;
  logic [7:0]       cnt;
  logic [7:0]       duty_active;

  logic             tick;
  logic             wrap;
  logic             pwm_raw;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [15:0]      out_nxt;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign tick = (presc == PRESC_MAX);
  // Last step of the period: the duty buffer reloads here so the new value
  // applies from cnt == 0 of the following period.
  assign wrap = tick && (cnt == 8'hFF);

  always_comb begin
    pwm_raw = 1'b0;
    out_nxt = '0;
    // 0xFF is special-cased so full duty never dips low at cnt == 255.
    if (duty_active == 8'hFF) begin
      pwm_raw = 1'b1;
    end else begin
      pwm_raw = (cnt < duty_active);
    end
    // Disabled pins are low; enabled pins either follow PWM or sit high.
    out_nxt = en_out & (~en_pwm | {16{pwm_raw}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc        <= '0;
      cnt          <= '0;
      duty_active  <= '0;
      out          <= '0;
      pwm_level    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      if (tick) begin
        presc <= '0;
        cnt   <= cnt + 8'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (wrap) begin
        duty_active <= pwm_duty_cycle;
      end
      pwm_level    <= pwm_raw;
      period_start <= wrap;
      out          <= out_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_output_controller.sv
module tb_pwm_output_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty4;
  logic [7:0]  duty1;

  logic [15:0] out4, out1;
  logic        lvl4, lvl1, ps4, ps1;

  // Reference state: edges since reset release and the duty in force per DUT.
  int          n;
  logic [7:0]  dcap4, dcap1;
  logic [15:0] e_out4, e_out1;
  logic        e_lvl4, e_lvl1, e_ps4, e_ps1;

  int checks = 0;
  int errors = 0;
  int hi4, hi1;
  int first_ps4 = -1;

  always #5 clk = ~clk;

  pwm_output_controller #(.CLK_DIV(4), .DIV_W(12)) dut4 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty4),
    .out             (out4),
    .pwm_level       (lvl4),
    .period_start    (ps4)
  );

  pwm_output_controller #(.CLK_DIV(1), .DIV_W(12)) dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty1),
    .out             (out1),
    .pwm_level       (lvl1),
    .period_start    (ps1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  // Expected outputs after the next edge, from the step index implied by the
  // number of edges already taken (nn) and the duty captured for this period.
  function automatic void ref_edge(input int cd, input int nn, input logic [7:0] dcap,
                                   input logic [7:0] duty, output logic [15:0] eo,
                                   output logic el, output logic ep, output logic [7:0] dn);
    int  c;
    logic raw;
    c   = (nn / cd) % 256;
    raw = (dcap == 8'hFF) || (c < int'(dcap));
    eo  = en_out & (~en_pwm | {16{raw}});
    el  = raw;
    ep  = ((nn + 1) % (256 * cd)) == 0;
    dn  = ep ? duty : dcap;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      n = 0; dcap4 = '0; dcap1 = '0;
      e_out4 = '0; e_out1 = '0; e_lvl4 = 0; e_lvl1 = 0; e_ps4 = 0; e_ps1 = 0;
    end else begin
      ref_edge(4, n, dcap4, duty4, e_out4, e_lvl4, e_ps4, dcap4);
      ref_edge(1, n, dcap1, duty1, e_out1, e_lvl1, e_ps1, dcap1);
      n++;
    end
    @(negedge clk);
    check("out4", out4, e_out4);
    check("lvl4", lvl4, e_lvl4);
    check("ps4",  ps4,  e_ps4);
    check("out1", out1, e_out1);
    check("lvl1", lvl1, e_lvl1);
    check("ps1",  ps1,  e_ps1);
    if (out4[0]) hi4++;
    if (out1[0]) hi1++;
    if (ps4 && first_ps4 < 0) first_ps4 = n;
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (n < target && guard < 20000) begin
      tick();
      guard++;
    end
    check("run_to_reached", n, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog edge=%0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    n = 0;
    rst_n  = 1'b0;
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    duty4  = 8'h80;
    duty1  = 8'h01;

    // Reset with nonzero inputs: everything held at zero.
    repeat (3) tick();
    check("rst_out4", out4, 16'h0);
    check("rst_ps4",  ps4,  1'b0);

    // Static enables.
    rst_n = 1'b1;
    tick();
    check("en_static", out4, 16'hFFFF);
    tick(); tick();
    en_out = 16'h00F0;
    tick();
    check("en_change4", out4, 16'h00F0);
    check("en_change1", out1, 16'h00F0);

    // Period 1 ends at edge 1024 with the first period_start.
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    run_to(1024);
    check("first_ps", first_ps4, 1024);

    // Period 2: duty 0x80 -> 512 high cycles; CLK_DIV=1 duty 1 -> 1 per 256.
    hi4 = 0; hi1 = 0;
    duty4 = 8'h00;
    run_to(2048);
    check("p2_hi4", hi4, 512);
    check("p2_hi1", hi1, 4);

    // Period 3: duty 0 -> never high. Duty change on dut1 in its exact wrap cycle.
    hi4 = 0; hi1 = 0;
    duty4 = 8'hFF;
    run_to(2303);
    duty1 = 8'h10;
    run_to(2304);
    check("wrap_old_hi1", hi1, 1);
    hi1 = 0;
    run_to(2560);
    check("wrap_new_hi1", hi1, 16);
    run_to(3072);
    check("p3_hi4", hi4, 0);

    // Period 4: duty 0xFF -> high every cycle.
    hi4 = 0;
    duty4 = 8'h40;
    run_to(4096);
    check("p4_hi4", hi4, 1024);

    // Period 5: mid-period write at cnt = 100 must not disturb this period.
    hi4 = 0;
    run_to(4096 + 400);
    duty4 = 8'hC0;
    run_to(5120);
    check("p5_hi4", hi4, 256);

    // Period 6: the new duty now applies.
    hi4 = 0;
    run_to(6144);
    check("p6_hi4", hi4, 768);

    // Randomized enables, selects and duties.
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        en_out = 16'($urandom);
        en_pwm = 16'($urandom);
        case ($urandom_range(0, 3))
          0: duty4 = 8'h00;
          1: duty4 = 8'hFF;
          default: duty4 = 8'($urandom);
        endcase
        duty1 = 8'($urandom);
      end
      tick();
    end

    // Mid-period reset with out[0] high.
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty4  = 8'hFF;
    duty1  = 8'hFF;
    run_to(n + 2048);
    check("pre_rst_hi", out4[0], 1'b1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_out4", out4, 16'h0);
    check("mid_rst_lvl4", lvl4, 1'b0);
    rst_n = 1'b1;
    hi4 = 0;
    run_to(1024);
    check("post_rst_hi4", hi4, 0);
    hi4 = 0;
    run_to(2048);
    check("post_rst_p2_hi4", hi4, 1024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
